// File: rtl/mesh_network_interface.sv
// mesh_network_interface: bridge between a processing element and the local
// port of a mesh router. The TX path turns PE messages into flits with an
// 8-bit destination ID in the top byte. The RX path strips that byte off and
// hands the payload to the PE. Each direction is buffered by a FIFO_DEPTH-entry
// FIFO with valid/ready handshakes on both sides.
// Optional feature macro: MESH_NI_RX_CHECK_EN. When it is defined, incoming
// flits whose header does not match this node are dropped and counted.
`timescale 1ns/1ps
module mesh_network_interface #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned X_COORD     = 0,
    parameter int unsigned Y_COORD     = 0,
    parameter int unsigned MESH_SIZE_X = 4,
    parameter int unsigned MESH_SIZE_Y = 4,
    parameter int unsigned FIFO_DEPTH  = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [3:0]                    pe_tx_dest_x,
    input  logic [3:0]                    pe_tx_dest_y,
    input  logic [DATA_WIDTH-9:0]         pe_tx_payload,
    input  logic                          pe_tx_valid,
    output logic                          pe_tx_ready,
    output logic [DATA_WIDTH-1:0]         noc_out_data,
    output logic                          noc_out_valid,
    input  logic                          noc_out_ready,
    input  logic [DATA_WIDTH-1:0]         noc_in_data,
    input  logic                          noc_in_valid,
    output logic                          noc_in_ready,
    output logic [DATA_WIDTH-9:0]         pe_rx_payload,
    output logic                          pe_rx_valid,
    input  logic                          pe_rx_ready,
    output logic [$clog2(FIFO_DEPTH):0]   tx_level,
    output logic [$clog2(FIFO_DEPTH):0]   rx_level,
    output logic [7:0]                    tx_err_count,
    output logic [7:0]                    rx_drop_count
);

    localparam int unsigned PW     = $clog2(FIFO_DEPTH);
    localparam int unsigned LW     = PW + 1;
    localparam int unsigned PAY_W  = DATA_WIDTH - 8;
    localparam logic [7:0]  OWN_ID = 8'(Y_COORD * MESH_SIZE_X + X_COORD);

    // ---------------- TX path ----------------
    logic [DATA_WIDTH-1:0] tx_mem [FIFO_DEPTH];
    logic [PW-1:0]         tx_wr_ptr;
    logic [PW-1:0]         tx_rd_ptr;
    logic [7:0]            tx_dest_id;
    logic                  tx_bad_dest;
    logic                  tx_accept;
    logic                  tx_push;
    logic                  tx_pop;

    // Destination ID computed at 32-bit precision, then truncated to a byte
    assign tx_dest_id  = 8'(32'(pe_tx_dest_y) * MESH_SIZE_X + 32'(pe_tx_dest_x));
    assign tx_bad_dest = (32'(pe_tx_dest_x) >= MESH_SIZE_X) ||
                         (32'(pe_tx_dest_y) >= MESH_SIZE_Y);

    assign pe_tx_ready   = (tx_level != LW'(FIFO_DEPTH));
    assign noc_out_valid = (tx_level != '0);
    assign noc_out_data  = tx_mem[tx_rd_ptr];

    assign tx_accept = pe_tx_valid && pe_tx_ready;
    assign tx_push   = tx_accept && !tx_bad_dest;
    assign tx_pop    = noc_out_valid && noc_out_ready;

    // TX FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tx_wr_ptr <= '0;
            tx_rd_ptr <= '0;
            tx_level  <= '0;
        end else begin
            if (tx_push) tx_wr_ptr <= tx_wr_ptr + PW'(1);
            if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + PW'(1);
            if (tx_push && !tx_pop)      tx_level <= tx_level + LW'(1);
            else if (!tx_push && tx_pop) tx_level <= tx_level - LW'(1);
        end
    end

    // TX FIFO storage; a full FIFO never pushes, so the write slot is always free
    always_ff @(posedge clk) begin
        if (rst_n && tx_push) tx_mem[tx_wr_ptr] <= {tx_dest_id, pe_tx_payload};
    end

    // Saturating count of accepted messages with an out-of-mesh destination
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tx_err_count <= '0;
        end else if (tx_accept && tx_bad_dest && (tx_err_count != 8'hFF)) begin
            tx_err_count <= tx_err_count + 8'd1;
        end
    end

    // ---------------- RX path ----------------
    logic [PAY_W-1:0] rx_mem [FIFO_DEPTH];
    logic [PW-1:0]    rx_wr_ptr;
    logic [PW-1:0]    rx_rd_ptr;
    logic             rx_accept;
    logic             rx_push;
    logic             rx_pop;

    assign noc_in_ready  = (rx_level != LW'(FIFO_DEPTH));
    assign pe_rx_valid   = (rx_level != '0);
    assign pe_rx_payload = rx_mem[rx_rd_ptr];

    assign rx_accept = noc_in_valid && noc_in_ready;
    assign rx_pop    = pe_rx_valid && pe_rx_ready;

`ifdef MESH_NI_RX_CHECK_EN
    logic rx_hdr_ok;

    assign rx_hdr_ok = (noc_in_data[DATA_WIDTH-1 -: 8] == OWN_ID);
    assign rx_push   = rx_accept && rx_hdr_ok;

    // Saturating count of consumed flits addressed to another node
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_drop_count <= '0;
        end else if (rx_accept && !rx_hdr_ok && (rx_drop_count != 8'hFF)) begin
            rx_drop_count <= rx_drop_count + 8'd1;
        end
    end
`else
    logic unused_rx_hdr;

    assign rx_push       = rx_accept;
    assign rx_drop_count = 8'd0;
    // Header byte and node ID are only meaningful when header checking is built in
    assign unused_rx_hdr = ^{noc_in_data[DATA_WIDTH-1 -: 8], OWN_ID};
`endif

    // RX FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_wr_ptr <= '0;
            rx_rd_ptr <= '0;
            rx_level  <= '0;
        end else begin
            if (rx_push) rx_wr_ptr <= rx_wr_ptr + PW'(1);
            if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + PW'(1);
            if (rx_push && !rx_pop)      rx_level <= rx_level + LW'(1);
            else if (!rx_push && rx_pop) rx_level <= rx_level - LW'(1);
        end
    end

    // RX FIFO storage holds only the payload; the header is dropped on entry
    always_ff @(posedge clk) begin
        if (rst_n && rx_push) rx_mem[rx_wr_ptr] <= noc_in_data[PAY_W-1:0];
    end

endmodule

// File: tb/tb_mesh_network_interface.sv
// Scoreboard bench for mesh_network_interface on node (x=2, y=1) of a 4x4 mesh.
`timescale 1ns/1ps
module tb_mesh_network_interface;

    localparam int unsigned DW    = 32;
    localparam int unsigned MX    = 4;
    localparam int unsigned MY    = 4;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned XC    = 2;
    localparam int unsigned YC    = 1;
    localparam logic [7:0]  OWN   = 8'(YC * MX + XC);
`ifdef MESH_NI_RX_CHECK_EN
    localparam bit RX_CHECK = 1'b1;
`else
    localparam bit RX_CHECK = 1'b0;
`endif

    logic          clk;
    logic          rst_n;
    logic [3:0]    pe_tx_dest_x;
    logic [3:0]    pe_tx_dest_y;
    logic [23:0]   pe_tx_payload;
    logic          pe_tx_valid;
    logic          pe_tx_ready;
    logic [31:0]   noc_out_data;
    logic          noc_out_valid;
    logic          noc_out_ready;
    logic [31:0]   noc_in_data;
    logic          noc_in_valid;
    logic          noc_in_ready;
    logic [23:0]   pe_rx_payload;
    logic          pe_rx_valid;
    logic          pe_rx_ready;
    logic [2:0]    tx_level;
    logic [2:0]    rx_level;
    logic [7:0]    tx_err_count;
    logic [7:0]    rx_drop_count;

    mesh_network_interface #(
        .DATA_WIDTH(DW), .X_COORD(XC), .Y_COORD(YC),
        .MESH_SIZE_X(MX), .MESH_SIZE_Y(MY), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .pe_tx_dest_x(pe_tx_dest_x), .pe_tx_dest_y(pe_tx_dest_y),
        .pe_tx_payload(pe_tx_payload), .pe_tx_valid(pe_tx_valid),
        .pe_tx_ready(pe_tx_ready),
        .noc_out_data(noc_out_data), .noc_out_valid(noc_out_valid),
        .noc_out_ready(noc_out_ready),
        .noc_in_data(noc_in_data), .noc_in_valid(noc_in_valid),
        .noc_in_ready(noc_in_ready),
        .pe_rx_payload(pe_rx_payload), .pe_rx_valid(pe_rx_valid),
        .pe_rx_ready(pe_rx_ready),
        .tx_level(tx_level), .rx_level(rx_level),
        .tx_err_count(tx_err_count), .rx_drop_count(rx_drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] txq[$];
    logic [23:0] rxq[$];
    int          exp_tx_err = 0;
    int          exp_drop   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out at %0t", name, $time);
    endtask

    function automatic logic [7:0] node_id(input int x, input int y);
        return 8'(y * int'(MX) + x);
    endfunction

    // Reference model, TX input side: record accepted messages
    always @(negedge clk) begin
        if (!rst_n) begin
            txq.delete();
            exp_tx_err = 0;
        end else if (pe_tx_valid && pe_tx_ready) begin
            if (int'(pe_tx_dest_x) >= int'(MX) || int'(pe_tx_dest_y) >= int'(MY)) begin
                if (exp_tx_err < 255) exp_tx_err++;
            end else begin
                txq.push_back({node_id(int'(pe_tx_dest_x), int'(pe_tx_dest_y)), pe_tx_payload});
            end
        end
    end

    // TX monitor: the presented head must match the oldest expected flit
    always @(negedge clk) begin
        if (rst_n && noc_out_valid) begin
            if (txq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL tx_unexpected: flit 0x%0h with nothing expected", noc_out_data);
            end else begin
                chk("tx_flit", noc_out_data, txq[0]);
                if (noc_out_ready) void'(txq.pop_front());
            end
        end
    end

    // Reference model, RX input side: record accepted flits
    always @(negedge clk) begin
        if (!rst_n) begin
            rxq.delete();
            exp_drop = 0;
        end else if (noc_in_valid && noc_in_ready) begin
            if (RX_CHECK && noc_in_data[31:24] != OWN) begin
                if (exp_drop < 255) exp_drop++;
            end else begin
                rxq.push_back(noc_in_data[23:0]);
            end
        end
    end

    // RX monitor
    always @(negedge clk) begin
        if (rst_n && pe_rx_valid) begin
            if (rxq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rx_unexpected: payload 0x%0h with nothing expected", pe_rx_payload);
            end else begin
                chk("rx_payload", 32'(pe_rx_payload), 32'(rxq[0]));
                if (pe_rx_ready) void'(rxq.pop_front());
            end
        end
    end

    task automatic tx_offer(input int x, input int y, input logic [23:0] p);
        @(posedge clk); #1;
        pe_tx_dest_x  = 4'(x);
        pe_tx_dest_y  = 4'(y);
        pe_tx_payload = p;
        pe_tx_valid   = 1'b1;
    endtask

    // Hold the offer until it is taken; returns just after the accepting edge
    task automatic tx_wait();
        bit done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (pe_tx_ready) done = 1'b1;
        end
        if (done) begin
            @(posedge clk); #1;
        end else begin
            timeout_fail("tx_accept");
        end
        pe_tx_valid = 1'b0;
    endtask

    task automatic tx_send(input int x, input int y, input logic [23:0] p);
        tx_offer(x, y, p);
        tx_wait();
    endtask

    task automatic rx_send(input logic [31:0] d);
        bit done = 1'b0;
        @(posedge clk); #1;
        noc_in_data  = d;
        noc_in_valid = 1'b1;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (noc_in_ready) done = 1'b1;
        end
        if (done) begin
            @(posedge clk); #1;
        end else begin
            timeout_fail("rx_accept");
        end
        noc_in_valid = 1'b0;
    endtask

    task automatic drain();
        bit done = 1'b0;
        @(posedge clk); #1;
        pe_tx_valid   = 1'b0;
        noc_in_valid  = 1'b0;
        noc_out_ready = 1'b1;
        pe_rx_ready   = 1'b1;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (txq.size() == 0 && rxq.size() == 0) done = 1'b1;
        end
        if (!done) timeout_fail("drain");
        @(posedge clk); #1;
        chk("tx_level_drained", 32'(tx_level), 32'd0);
        chk("rx_level_drained", 32'(rx_level), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int n;
        bit stop;
        rst_n = 1'b0;
        pe_tx_dest_x = '0; pe_tx_dest_y = '0; pe_tx_payload = '0; pe_tx_valid = 1'b0;
        noc_out_ready = 1'b0; noc_in_data = '0; noc_in_valid = 1'b0; pe_rx_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_tx_level", 32'(tx_level), 32'd0);
        chk("rst_rx_level", 32'(rx_level), 32'd0);
        chk("rst_noc_out_valid", 32'(noc_out_valid), 32'd0);
        chk("rst_pe_rx_valid", 32'(pe_rx_valid), 32'd0);
        chk("rst_pe_tx_ready", 32'(pe_tx_ready), 32'd1);
        chk("rst_noc_in_ready", 32'(noc_in_ready), 32'd1);
        chk("rst_tx_err", 32'(tx_err_count), 32'd0);
        chk("rst_rx_drop", 32'(rx_drop_count), 32'd0);
        rst_n = 1'b1;

        // Single message to (3,1): ID 7
        noc_out_ready = 1'b1;
        tx_send(3, 1, 24'hABCDEF);
        chk("t1_valid", 32'(noc_out_valid), 32'd1);
        chk("t1_flit", noc_out_data, 32'h07ABCDEF);
        @(posedge clk); #1;
        chk("t1_level", 32'(tx_level), 32'd0);

        // Back-pressure: four accepted, fifth refused, head stable
        noc_out_ready = 1'b0;
        for (int i = 0; i < 4; i++) tx_send(1, 1, 24'(i + 1));
        tx_offer(0, 0, 24'h000005);
        repeat (3) begin
            @(negedge clk);
            chk("t2_tx_ready_full", 32'(pe_tx_ready), 32'd0);
            chk("t2_head_stable", noc_out_data, 32'h05000001);
        end
        chk("t2_tx_level_full", 32'(tx_level), 32'd4);
        @(posedge clk); #1;
        pe_tx_valid   = 1'b0;
        noc_out_ready = 1'b1;
        n = 0;
        stop = 1'b0;
        for (int k = 0; k < 10 && !stop; k++) begin
            @(negedge clk);
            if (noc_out_valid) n++;
            else stop = 1'b1;
        end
        chk("t2_burst_len", 32'(n), 32'd4);
        chk("t2_level_after", 32'(tx_level), 32'd0);

        // Out-of-range destination, then saturation
        tx_send(4, 0, 24'h000001);
        chk("t3_no_flit", 32'(noc_out_valid), 32'd0);
        chk("t3_err_one", 32'(tx_err_count), 32'd1);
        pe_tx_valid = 1'b1;
        repeat (300) begin
            pe_tx_dest_x  = 4'($urandom_range(4, 15));
            pe_tx_dest_y  = 4'($urandom_range(0, 15));
            pe_tx_payload = 24'($urandom);
            @(posedge clk); #1;
        end
        pe_tx_valid = 1'b0;
        chk("t3_err_sat", 32'(tx_err_count), 32'd255);
        chk("t3_err_model", 32'(tx_err_count), 32'(exp_tx_err));

        // RX delivery and back-pressure
        pe_rx_ready = 1'b0;
        rx_send(32'h06123456);
        chk("t4_rx_valid", 32'(pe_rx_valid), 32'd1);
        chk("t4_rx_payload", 32'(pe_rx_payload), 32'h00123456);
        for (int i = 0; i < 3; i++) rx_send({OWN, 24'($urandom)});
        @(negedge clk);
        chk("t4_noc_in_ready_full", 32'(noc_in_ready), 32'd0);
        chk("t4_rx_level_full", 32'(rx_level), 32'd4);
        drain();

        // Flit with a foreign header
        pe_rx_ready = 1'b0;
        rx_send(32'h05000001);
`ifdef MESH_NI_RX_CHECK_EN
        chk("t5_dropped_valid", 32'(pe_rx_valid), 32'd0);
        chk("t5_drop_count", 32'(rx_drop_count), 32'd1);
        chk("t5_rx_level", 32'(rx_level), 32'd0);
`else
        chk("t5_kept_valid", 32'(pe_rx_valid), 32'd1);
        chk("t5_kept_payload", 32'(pe_rx_payload), 32'h00000001);
        chk("t5_drop_count", 32'(rx_drop_count), 32'd0);
`endif
        drain();

        // Fill both FIFOs, then reset for one cycle
        noc_out_ready = 1'b0;
        pe_rx_ready   = 1'b0;
        tx_send(0, 7, 24'h00BEEF);
        for (int i = 0; i < 4; i++) tx_send(i, 3 - i, 24'($urandom));
        for (int i = 0; i < 4; i++) rx_send({OWN, 24'($urandom)});
        chk("t6_tx_full", 32'(tx_level), 32'd4);
        chk("t6_rx_full", 32'(rx_level), 32'd4);
        @(posedge clk); #1;
        rst_n         = 1'b0;
        noc_out_ready = 1'b1;
        pe_rx_ready   = 1'b1;
        @(posedge clk); #1;
        rst_n         = 1'b1;
        noc_out_ready = 1'b0;
        pe_rx_ready   = 1'b0;
        chk("t6_tx_level", 32'(tx_level), 32'd0);
        chk("t6_rx_level", 32'(rx_level), 32'd0);
        chk("t6_noc_out_valid", 32'(noc_out_valid), 32'd0);
        chk("t6_pe_rx_valid", 32'(pe_rx_valid), 32'd0);
        chk("t6_pe_tx_ready", 32'(pe_tx_ready), 32'd1);
        chk("t6_noc_in_ready", 32'(noc_in_ready), 32'd1);
        chk("t6_tx_err", 32'(tx_err_count), 32'd0);
        chk("t6_rx_drop", 32'(rx_drop_count), 32'd0);

        // Random bidirectional traffic
        repeat (2000) begin
            @(posedge clk); #1;
            pe_tx_valid   = 1'($urandom_range(0, 1));
            pe_tx_dest_x  = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(4, 15))
                                                         : 4'($urandom_range(0, 3));
            pe_tx_dest_y  = 4'($urandom_range(0, 3));
            pe_tx_payload = 24'($urandom);
            noc_out_ready = 1'($urandom_range(0, 1));
            noc_in_valid  = 1'($urandom_range(0, 1));
            noc_in_data   = {(($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : OWN),
                             24'($urandom)};
            pe_rx_ready   = 1'($urandom_range(0, 1));
        end
        drain();
        chk("rand_tx_err", 32'(tx_err_count), 32'(exp_tx_err));
        chk("rand_rx_drop", 32'(rx_drop_count), 32'(exp_drop));
        chk("rand_tx_ready", 32'(pe_tx_ready), 32'd1);
        chk("rand_noc_in_ready", 32'(noc_in_ready), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
